// File: rtl/link_rx_pkg.sv
// Shared types, widths and FIFO pointer-compare helpers for the link receive path.
package link_rx_pkg;

  localparam int unsigned LINK_BEAT_W = 32;
  localparam int unsigned WORD_W      = 2 * LINK_BEAT_W;
  localparam int unsigned PTR_MAX_W   = 32;

  typedef enum logic {
    HALF0 = 1'b0,
    HALF1 = 1'b1
  } half_state_e;

  // Pointers carry one extra wrap bit above the lg-bit index.
  function automatic logic ptr_full(input logic [PTR_MAX_W-1:0] wr,
                                    input logic [PTR_MAX_W-1:0] rd,
                                    input int unsigned          lg);
    logic [PTR_MAX_W-1:0] diff;
    logic [PTR_MAX_W-1:0] mask;
    diff = wr ^ rd;
    mask = (PTR_MAX_W'(1) << (lg + 1)) - PTR_MAX_W'(1);
    return (diff & mask) == (PTR_MAX_W'(1) << lg);
  endfunction

  function automatic logic ptr_empty(input logic [PTR_MAX_W-1:0] wr,
                                     input logic [PTR_MAX_W-1:0] rd,
                                     input int unsigned          lg);
    logic [PTR_MAX_W-1:0] mask;
    mask = (PTR_MAX_W'(1) << (lg + 1)) - PTR_MAX_W'(1);
    return ((wr ^ rd) & mask) == '0;
  endfunction

endpackage

// File: rtl/link_rx_fifo.sv
// Single-clock 1W/1R FIFO with registered wrap-bit pointers; head word is zero when empty.
module link_rx_fifo
  import link_rx_pkg::*;
#(
  parameter int unsigned DATA_W   = WORD_W,
  parameter int unsigned LG_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                push_i,
  input  logic                pop_i,
  input  logic [DATA_W-1:0]   data_i,
  output logic [DATA_W-1:0]   data_o,
  output logic                full_o,
  output logic                empty_o,
  output logic [LG_DEPTH:0]   count_o
);

  localparam int unsigned DEPTH = 1 << LG_DEPTH;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [LG_DEPTH:0] wr_q;
  logic [LG_DEPTH:0] rd_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + (LG_DEPTH + 1)'(1);
      if (pop_i)  rd_q <= rd_q + (LG_DEPTH + 1)'(1);
    end
  end

  // Storage is not reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_q[LG_DEPTH-1:0]] <= data_i;
  end

  always_comb begin
    full_o  = ptr_full(PTR_MAX_W'(wr_q), PTR_MAX_W'(rd_q), LG_DEPTH);
    empty_o = ptr_empty(PTR_MAX_W'(wr_q), PTR_MAX_W'(rd_q), LG_DEPTH);
    count_o = wr_q - rd_q;
    data_o  = empty_o ? '0 : mem_q[rd_q[LG_DEPTH-1:0]];
  end

endmodule

// File: rtl/link_rx_word_assembler.sv
// Pairs incoming half-word beats into words (low half first), buffers them, and returns
// credits to the link as one token toggle per batch of consumed words.
module link_rx_word_assembler
  import link_rx_pkg::*;
#(
  parameter int unsigned BEAT_W         = LINK_BEAT_W,
  parameter int unsigned LG_FIFO_DEPTH  = 4,
  parameter int unsigned LG_TOKEN_BATCH = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     beat_v_i,
  input  logic [BEAT_W-1:0]        beat_data_i,
  output logic                     valid_o,
  output logic [2*BEAT_W-1:0]      data_o,
  input  logic                     yumi_i,
  output logic                     token_o,
  output logic [LG_FIFO_DEPTH:0]   count_o,
  output logic                     overflow_o
);

  half_state_e               state_q;
  logic [BEAT_W-1:0]         lo_q;
  logic                      overflow_q;
  logic [LG_TOKEN_BATCH-1:0] batch_q;
  logic                      token_q;

  logic fifo_full;
  logic fifo_empty;
  logic pop;
  logic push_want;
  logic push_ok;

  // A full FIFO still accepts a word when the head leaves in the same cycle.
  always_comb begin
    pop       = yumi_i & ~fifo_empty;
    push_want = beat_v_i & (state_q == HALF1);
    push_ok   = push_want & (~fifo_full | pop);
  end

  link_rx_fifo #(
    .DATA_W   (2 * BEAT_W),
    .LG_DEPTH (LG_FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push_ok),
    .pop_i   (pop),
    .data_i  ({beat_data_i, lo_q}),
    .data_o  (data_o),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (count_o)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= HALF0;
      lo_q       <= '0;
      overflow_q <= 1'b0;
      batch_q    <= '0;
      token_q    <= 1'b0;
    end else begin
      if (beat_v_i) begin
        case (state_q)
          HALF0: begin
            lo_q    <= beat_data_i;
            state_q <= HALF1;
          end
          HALF1: state_q <= HALF0;
          default: state_q <= HALF0;
        endcase
      end
      if (push_want && !push_ok) overflow_q <= 1'b1;
      if (pop) begin
        batch_q <= batch_q + LG_TOKEN_BATCH'(1);
        if (&batch_q) token_q <= ~token_q;
      end
    end
  end

  assign valid_o    = ~fifo_empty;
  assign token_o    = token_q;
  assign overflow_o = overflow_q;

  // Consuming with nothing at the head is a protocol error by the core.
  a_yumi_needs_valid: assert property (@(posedge clk) disable iff (!rst_n) yumi_i |-> valid_o);

endmodule
